bpsk_symbol_demod: RTL and testbench

Downstream stage of the receiver's binary preamble correlator. Waits for the correlator's lock pulse, then slices the 1-bit sign-sampled BPSK stream into symbol windows of WAVELENGTH samples. It correlates each window against one period of the reference carrier sign pattern and decides each bit by majority. Bits are packed MSB-first into words, delivered over a valid/ready handshake, for a fixed-length frame.

---
 rtl/bpsk_symbol_demod.sv | 121 ++++++++++++
 tb/tb_bpsk_symbol_demod.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_symbol_demod.sv
// BPSK symbol demodulator: after preamble lock, correlates each carrier-period window of
// sign samples against the reference pattern, decides bits by majority, and frames them into words.
module bpsk_symbol_demod #(
  parameter int WAVELENGTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  signal,
  input  logic                  sync_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_end,
  output logic                  overrun,
  output logic                  busy
);

  localparam int PW = (WAVELENGTH > 1) ? $clog2(WAVELENGTH) : 1;
  localparam int AW = $clog2(WAVELENGTH + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] RECEIVE = 1'b1;

  localparam logic [PW-1:0] LAST_PHASE = PW'(WAVELENGTH - 1);
  localparam logic [PW-1:0] HALF_PHASE = PW'(WAVELENGTH / 2);
  localparam logic [AW:0]   WAVE_LEN   = (AW + 1)'(WAVELENGTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);
  localparam logic [FW-1:0] LAST_WORD  = FW'(FRAME_WORDS - 1);

  logic [0:0]            state;
  logic [PW-1:0]         phase;
  logic [AW-1:0]         agree;
  logic [BW-1:0]         bit_cnt;
  logic [FW-1:0]         word_cnt;
  logic [DATA_WIDTH-2:0] shreg;

  logic                  ref_sign;
  logic [AW-1:0]         agree_next;
  logic                  sym_bit;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_end;
  logic                  load;

  // Agreement includes the current sample, so the decision covers the full window.
  always_comb begin
    ref_sign   = (phase < HALF_PHASE);
    agree_next = agree + AW'(signal == ref_sign);
    sym_bit    = ({agree_next, 1'b0} > WAVE_LEN);
    word       = {shreg, sym_bit};
    word_end   = (state == RECEIVE) && (phase == LAST_PHASE) && (bit_cnt == LAST_BIT);
    load       = word_end && (!data_valid || data_ready);
  end

  assign busy = (state == RECEIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      phase      <= '0;
      agree      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (word_end && !load) begin
        overrun <= 1'b1;
      end

      case (state)
        HUNT: begin
          if (sync_done) begin
            state    <= RECEIVE;
            phase    <= '0;
            agree    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        RECEIVE: begin
          if (phase == LAST_PHASE) begin
            phase <= '0;
            agree <= '0;
            shreg <= word[DATA_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + FW'(1);
              // frame_end only marks a frame whose final word actually reached data_out.
              if (word_cnt == LAST_WORD) begin
                state     <= HUNT;
                word_cnt  <= '0;
                frame_end <= load;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            phase <= phase + PW'(1);
            agree <= agree_next;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_demod.sv
// Self-checking bench for bpsk_symbol_demod: table-driven frames, randomized noisy frames,
// backpressure, relock and abort sequences, all checked cycle by cycle against a frame-level model.
module tb_bpsk_symbol_demod;

  localparam int W         = 8;
  localparam int DW        = 8;
  localparam int NW        = 4;
  localparam int WORD_LEN  = W * DW;
  localparam int FRAME_LEN = WORD_LEN * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          signal;
  logic          sync_done;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_end;
  logic          overrun;
  logic          busy;

  bpsk_symbol_demod #(.WAVELENGTH(W), .DATA_WIDTH(DW), .FRAME_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .signal(signal), .sync_done(sync_done),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_end(frame_end), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] words;
    int          noise;
    logic [31:0] expected;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic          exp_valid, exp_frame_end, exp_overrun, exp_busy;
  logic [DW-1:0] exp_data;
  bit            samples [FRAME_LEN];
  logic [DW-1:0] got_words [NW];
  int            got_cnt;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_output();
    check1("data_valid", 32'(data_valid), 32'(exp_valid));
    check1("data_out", 32'(data_out), 32'(exp_data));
    check1("frame_end", 32'(frame_end), 32'(exp_frame_end));
    check1("overrun", 32'(overrun), 32'(exp_overrun));
    check1("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Majority decision of each symbol window, computed straight from the sample array.
  function automatic logic [DW-1:0] model_word(input int n);
    logic [DW-1:0] w;
    int cnt, sym;
    w = '0;
    for (int b = 0; b < DW; b++) begin
      sym = n * DW + b;
      cnt = 0;
      for (int i = 0; i < W; i++)
        if (samples[sym * W + i] == (i < W / 2)) cnt++;
      w = {w[DW-2:0], (2 * cnt > W)};
    end
    return w;
  endfunction

  // k < 0 picks a random number (0..4) of inverted samples per symbol.
  task automatic build_samples(input logic [31:0] words, input int k);
    int idx [W];
    int j, t, kk;
    bit b;
    for (int sym = 0; sym < DW * NW; sym++) begin
      b = words[31 - sym];
      for (int i = 0; i < W; i++) begin
        samples[sym * W + i] = b ? (i < W / 2) : !(i < W / 2);
        idx[i] = i;
      end
      for (int i = W - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = idx[i]; idx[i] = idx[j]; idx[j] = t;
      end
      kk = (k < 0) ? $urandom_range(0, 4) : k;
      for (int i = 0; i < kk; i++)
        samples[sym * W + idx[i]] = !samples[sym * W + idx[i]];
    end
  endtask

  task automatic apply_stimulus(input bit complete, input logic [DW-1:0] w, input bit last);
    bit r, loaded;
    r = data_ready;
    @(posedge clk);
    #1;
    loaded = complete && (!exp_valid || r);
    if (loaded) begin
      exp_data  = w;
      exp_valid = 1'b1;
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    if (complete && !loaded) exp_overrun = 1'b1;
    exp_frame_end = loaded && last;
    if (loaded && got_cnt < NW) begin
      got_words[got_cnt] = data_out;
      got_cnt++;
    end
    check_output();
  endtask

  task automatic idle(input int n);
    sync_done  = 1'b0;
    data_ready = 1'b1;
    exp_busy   = 1'b0;
    for (int i = 0; i < n; i++) begin
      signal = 1'($urandom);
      apply_stimulus(1'b0, '0, 1'b0);
    end
  endtask

  // Starts a frame from HUNT; abort_at > 0 stops before sampling that frame edge.
  task automatic run_frame(input int release_c, input bit hold_sync, input int abort_at);
    bit complete;
    logic [DW-1:0] w;
    got_cnt    = 0;
    sync_done  = 1'b1;
    data_ready = (release_c == 0);
    signal     = 1'($urandom);
    exp_busy   = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= FRAME_LEN; c++) begin
      if (abort_at != 0 && c == abort_at) return;
      signal     = samples[c - 1];
      data_ready = (c >= release_c);
      sync_done  = hold_sync;
      exp_busy   = (c != FRAME_LEN);
      complete   = (c % WORD_LEN == 0);
      w          = complete ? model_word(c / WORD_LEN - 1) : '0;
      apply_stimulus(complete, w, c == FRAME_LEN);
    end
    sync_done = hold_sync;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'hA53CFF00, 0, 32'hA53CFF00};
    vecs[1] = '{32'hA5A5A5A5, 3, 32'hA5A5A5A5};
    vecs[2] = '{32'hA5A5A5A5, 4, 32'h00000000};
    vecs[3] = '{32'h3CC35A96, 1, 32'h3CC35A96};
    vecs[4] = '{32'hFF00FF00, 2, 32'hFF00FF00};
    vecs[5] = '{32'h12345678, 5, 32'hEDCBA987};

    exp_valid = 0; exp_frame_end = 0; exp_overrun = 0; exp_busy = 0; exp_data = '0;
    got_cnt = 0;

    // Reset with random inputs, then a long quiet stretch in HUNT.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      signal     = 1'($urandom);
      sync_done  = 1'($urandom);
      data_ready = 1'($urandom);
      @(posedge clk);
      #1;
      check_output();
    end
    reset = 1'b0;
    sync_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      signal     = 1'($urandom);
      data_ready = 1'($urandom);
      apply_stimulus(1'b0, '0, 1'b0);
    end

    $display("[TB] table-driven frames");
    foreach (vecs[v]) begin
      build_samples(vecs[v].words, vecs[v].noise);
      run_frame(0, 1'b0, 0);
      check1("word_count", 32'(got_cnt), 32'(NW));
      for (int n = 0; n < NW; n++)
        check1("table_word", 32'(got_words[n]), 32'(vecs[v].expected[31 - 8 * n -: 8]));
      idle(3);
    end

    $display("[TB] handshake coincident with word completion");
    build_samples($urandom, 0);
    run_frame(2 * WORD_LEN, 1'b0, 0);
    check1("no_overrun_coincident", 32'(overrun), 32'd0);
    idle(3);

    $display("[TB] random noisy frames");
    for (int f = 0; f < 4; f++) begin
      build_samples($urandom, -1);
      run_frame(0, 1'b0, 0);
      idle(2);
    end

    $display("[TB] backpressure");
    build_samples(32'hA53CFF00, 0);
    run_frame(150, 1'b0, 0);
    check1("overrun_sticky", 32'(overrun), 32'd1);
    idle(3);

    $display("[TB] sync_done held through frame, immediate relock");
    build_samples($urandom, 0);
    run_frame(0, 1'b1, 0);
    build_samples($urandom, 0);
    run_frame(0, 1'b0, 0);
    idle(3);

    $display("[TB] reset mid-frame");
    build_samples(32'h5A5A5A5A, 0);
    run_frame(0, 1'b0, 100);
    reset     = 1'b1;
    sync_done = 1'b1;
    #1;
    exp_valid = 0; exp_frame_end = 0; exp_overrun = 0; exp_busy = 0; exp_data = '0;
    check_output();
    @(posedge clk);
    #1;
    check_output();
    reset = 1'b0;
    idle(2);
    build_samples(32'hC0FFEE11, 0);
    run_frame(0, 1'b0, 0);
    for (int n = 0; n < NW; n++)
      check1("after_abort_word", 32'(got_words[n]), 32'((32'hC0FFEE11 >> (24 - 8 * n)) & 32'hFF));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
